// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-side fetch engine over a req/gnt + rvalid memory bus with flush and timeout.
// Optional macro FETCH_ALIGN_CHECK_EN reports misaligned fetch addresses as errors without a memory access.
`default_nettype none

module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR      = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  stall,
  input  logic                  flush,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  fetch_err,
  input  logic                  instr_ack,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    instr_valid_q, instr_valid_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    timeout_hit;

  // Saturating increment: the counter never wraps back to zero.
  assign cnt_inc     = (cnt_q == TIMEOUT_VAL) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == TIMEOUT_VAL);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      fetch_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      fetch_err_q   <= fetch_err_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    fetch_err_d   = fetch_err_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_req && !flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (fetch_addr[1:0] != 2'b00) begin
            instr_d       = NOP_INSTR;
            fetch_err_d   = 1'b1;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end else begin
            mem_addr_d = fetch_addr & ~ADDR_WIDTH'(3);
            mem_req_d  = 1'b1;
            state_d    = S_REQ;
          end
`else
          mem_addr_d = fetch_addr & ~ADDR_WIDTH'(3);
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
`endif
        end
      end

      S_REQ: begin
        if (mem_gnt) begin
          // A granted request must still have its response drained even when flushed.
          mem_req_d = 1'b0;
          cnt_d     = '0;
          state_d   = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_inc;
        if (flush) begin
          state_d = (mem_rvalid || timeout_hit) ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid) begin
          instr_d       = mem_rdata;
          fetch_err_d   = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end else if (timeout_hit) begin
          instr_d       = NOP_INSTR;
          fetch_err_d   = 1'b1;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end

      S_HOLD: begin
        if (flush || instr_ack) begin
          instr_valid_d = 1'b0;
          fetch_err_d   = 1'b0;
          state_d       = S_IDLE;
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (mem_rvalid || timeout_hit) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        mem_req_d     = 1'b0;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

  assign fetch_ready = (state_q == S_IDLE);
  assign stall       = (state_q != S_IDLE);
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign fetch_err   = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default parameters, TIMEOUT_CYCLES=16).
`default_nettype none

module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        stall;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic        fetch_err;
  logic        instr_ack = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16),
    .NOP_INSTR     (32'h0000_0000)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .stall      (stall),
    .flush      (flush),
    .instr_valid(instr_valid),
    .instr      (instr),
    .fetch_err  (fetch_err),
    .instr_ack  (instr_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check the IDLE/reset-visible output set.
  task automatic check_idle(input string tag);
    check({tag, ".fetch_ready"}, fetch_ready, 1);
    check({tag, ".stall"}, stall, 0);
    check({tag, ".mem_req"}, mem_req, 0);
    check({tag, ".instr_valid"}, instr_valid, 0);
  endtask

  // Issue a fetch from IDLE and take the grant immediately; leaves the unit in WAIT.
  task automatic start_to_wait(input logic [31:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check_idle("reset");
    check("reset.fetch_err", fetch_err, 0);
    check("reset.instr", instr, 32'h0);
    check("reset.mem_addr", mem_addr, 32'h0);
    RST = 1'b0;

    // Zero-wait fetch: fetch_req cycle 0, mem_req cycle 1, rvalid cycle 2, instr_valid cycle 3
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0004;
    tick();
    fetch_req = 1'b0;
    check("zw.c1.mem_req", mem_req, 1);
    check("zw.c1.mem_addr", mem_addr, 32'h0040_0004);
    check("zw.c1.stall", stall, 1);
    check("zw.c1.fetch_ready", fetch_ready, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("zw.c2.mem_req", mem_req, 0);
    check("zw.c2.instr_valid", instr_valid, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2008_0005;
    tick();
    mem_rvalid = 1'b0;
    check("zw.c3.instr_valid", instr_valid, 1);
    check("zw.c3.instr", instr, 32'h2008_0005);
    check("zw.c3.fetch_err", fetch_err, 0);
    check("zw.c3.stall", stall, 1);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check_idle("zw.after_ack");

    // Backpressure: grant withheld 3 cycles, ack withheld 4 cycles
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0100;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp.req.mem_req", mem_req, 1);
      check("bp.req.mem_addr", mem_addr, 32'h0040_0100);
      check("bp.req.stall", stall, 1);
      tick();
    end
    check("bp.req4.mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8C22_0008;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      check("bp.hold.instr_valid", instr_valid, 1);
      check("bp.hold.instr", instr, 32'h8C22_0008);
      check("bp.hold.stall", stall, 1);
      tick();
    end
    check("bp.hold5.instr_valid", instr_valid, 1);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check_idle("bp.after_ack");

    // Flush in WAIT, response arrives two cycles after the flush and is dropped
    start_to_wait(32'h0040_0200);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fw.drain.stall", stall, 1);
    check("fw.drain.fetch_ready", fetch_ready, 0);
    check("fw.drain.instr_valid", instr_valid, 0);
    tick();
    check("fw.drain2.stall", stall, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check_idle("fw.after_rvalid");
    check("fw.instr_kept", instr, 32'h8C22_0008);
    tick();
    check("fw.later.instr_valid", instr_valid, 0);

    // Flush in REQ without grant drops mem_req; flush in IDLE ignores fetch_req
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0300;
    tick();
    fetch_req = 1'b0;
    flush     = 1'b1;
    tick();
    check_idle("freq");
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    flush     = 1'b0;
    check_idle("fidle");

    // Timeout: 16 WAIT cycles without rvalid, then an error hold with the NOP word
    start_to_wait(32'h0040_0400);
    for (int i = 0; i < 16; i++) begin
      check("to.wait.instr_valid", instr_valid, 0);
      check("to.wait.stall", stall, 1);
      tick();
    end
    check("to.instr_valid", instr_valid, 1);
    check("to.instr", instr, 32'h0);
    check("to.fetch_err", fetch_err, 1);
    // Flush in HOLD drops instr_valid even with ack present
    flush     = 1'b1;
    instr_ack = 1'b1;
    tick();
    flush     = 1'b0;
    instr_ack = 1'b0;
    check_idle("fhold");
    check("fhold.fetch_err", fetch_err, 0);

    // Reset mid-WAIT abandons the fetch; a late rvalid is ignored
    start_to_wait(32'h0040_0500);
    check("rw.pre.stall", stall, 1);
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check_idle("rw.reset");
    check("rw.instr", instr, 32'h0);
    check("rw.mem_addr", mem_addr, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    check_idle("rw.late_rvalid");
    check("rw.late.instr", instr, 32'h0);

    // Misaligned fetch address
    fetch_req  = 1'b1;
    fetch_addr = 32'h0040_0002;
    tick();
    fetch_req = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis.mem_req", mem_req, 0);
    check("mis.instr_valid", instr_valid, 1);
    check("mis.fetch_err", fetch_err, 1);
    check("mis.instr", instr, 32'h0);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check_idle("mis.after_ack");
`else
    check("mis.mem_req", mem_req, 1);
    check("mis.mem_addr", mem_addr, 32'h0040_0000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0020;
    tick();
    mem_rvalid = 1'b0;
    check("mis.instr_valid", instr_valid, 1);
    check("mis.instr", instr, 32'h0000_0020);
    check("mis.fetch_err", fetch_err, 0);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check_idle("mis.after_ack");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
